// File: rtl/mem_responder.sv
// Byte-serial RAM responder on the request/ready four-phase memory bus; build option MEM_RESP_ALIGN_CHECK_EN.
// Latency N+WAIT_STATES+1 cycles from acceptance; ready held while request stays high.
module mem_responder #(
    parameter int         M_WIDTH     = 32,
    parameter int         AW          = 10,
    parameter int         WAIT_STATES = 0,
    parameter logic [1:0] MEM_ACC_8   = 2'b00,
    parameter logic [1:0] MEM_ACC_16  = 2'b01,
    parameter logic [1:0] MEM_ACC_32  = 2'b10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_request,
    input  logic [M_WIDTH-1:0] mem_addr,
    input  logic [1:0]         mem_data_width,
    input  logic               mem_we_out,
    input  logic [M_WIDTH-1:0] mem_data_out,
    output logic               mem_ready,
    output logic [M_WIDTH-1:0] mem_data_in,
    output logic               mem_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  ram [2**AW];
    logic [AW-1:0] addr_q;
    logic        we_q;
    logic [31:0] wdat_q;
    logic [1:0]  last_q;
    logic [1:0]  k_q;
    logic [15:0] wait_q;
    logic [31:0] shadow_q, shadow_d;
    logic [AW-1:0] byte_addr;
    logic [7:0]  rd_byte;
    logic        accept, mis, ram_we, ready_d, load_rdata;
    logic [1:0]  last_d;
    logic        unused_ok;

    assign byte_addr = addr_q + AW'(k_q);
    assign rd_byte   = ram[byte_addr];
    assign unused_ok = ^{mem_addr, mem_data_out, MEM_ACC_32};

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        mis        = 1'b0;
        ram_we     = 1'b0;
        shadow_d   = shadow_q;
        last_d     = 2'd3;
        load_rdata = 1'b0;
        case (mem_data_width)
            MEM_ACC_8:  last_d = 2'd0;
            MEM_ACC_16: last_d = 2'd1;
            default:    last_d = 2'd3;
        endcase
`ifdef MEM_RESP_ALIGN_CHECK_EN
        mis = ((mem_data_width == MEM_ACC_16) && mem_addr[0]) ||
              ((last_d == 2'd3) && (mem_addr[1:0] != 2'b00));
`endif
        case (state_q)
            IDLE: begin
                if (mem_request) begin
                    accept   = 1'b1;
                    shadow_d = '0;
                    state_d  = mis ? DONE : ACCESS;
                    // Misaligned reads complete with zero data.
                    load_rdata = mis && !mem_we_out;
                end
            end
            ACCESS: begin
                ram_we = we_q;
                if (!we_q) shadow_d[{k_q, 3'b000} +: 8] = rd_byte;
                if (k_q == last_q) begin
                    state_d    = (WAIT_STATES > 0) ? WAIT : DONE;
                    load_rdata = (WAIT_STATES == 0) && !we_q;
                end
            end
            WAIT: begin
                if (wait_q == 16'(WAIT_STATES - 1)) begin
                    state_d    = DONE;
                    load_rdata = !we_q;
                end
            end
            DONE: begin
                if (!mem_request) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready rises one cycle after DONE entry and falls on the edge that sees request low.
        ready_d = (state_q == DONE) && !(mem_ready && !mem_request);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdat_q      <= '0;
            last_q      <= '0;
            k_q         <= '0;
            wait_q      <= '0;
            shadow_q    <= '0;
            mem_ready   <= 1'b0;
            mem_data_in <= '0;
        end else begin
            state_q   <= state_d;
            mem_ready <= ready_d;
            shadow_q  <= shadow_d;
            if (accept) begin
                addr_q <= mem_addr[AW-1:0];
                we_q   <= mem_we_out;
                wdat_q <= mem_data_out[31:0];
                last_q <= last_d;
                k_q    <= '0;
            end else if (state_q == ACCESS) begin
                k_q <= k_q + 2'd1;
            end
            wait_q <= (state_q == WAIT) ? wait_q + 16'd1 : 16'd0;
            if (load_rdata) mem_data_in <= M_WIDTH'(shadow_d);
        end
    end

    // RAM is never cleared; reset only blocks the in-flight write.
    always_ff @(posedge clk) begin
        if (rst && ram_we) ram[byte_addr] <= wdat_q[{k_q, 3'b000} +: 8];
    end

`ifdef MEM_RESP_ALIGN_CHECK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q   <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            if (accept) err_q <= mis;
            mem_err <= ready_d && err_q;
        end
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: vector table plus read-data scoreboard on two instances (0 and 3 wait states).
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst0, rst3, req0, req3, we;
    logic [31:0] addr, wdata;
    logic [1:0]  width;
    logic        rdy0, rdy3, err0, err3;
    logic [31:0] din0, din3;
    logic        sel;
    logic        cur_rdy, cur_err;
    logic [31:0] cur_din;
    logic [31:0] last_rd [2];
    logic [31:0] exp_q [$];
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        bit          we;
        logic [1:0]  wd;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        int          lat;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    mem_responder #(.M_WIDTH(32), .AW(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst0), .mem_request(req0), .mem_addr(addr),
        .mem_data_width(width), .mem_we_out(we), .mem_data_out(wdata),
        .mem_ready(rdy0), .mem_data_in(din0), .mem_err(err0));

    mem_responder #(.M_WIDTH(32), .AW(10), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst(rst3), .mem_request(req3), .mem_addr(addr),
        .mem_data_width(width), .mem_we_out(we), .mem_data_out(wdata),
        .mem_ready(rdy3), .mem_data_in(din3), .mem_err(err3));

    assign cur_rdy = sel ? rdy3 : rdy0;
    assign cur_err = sel ? err3 : err0;
    assign cur_din = sel ? din3 : din0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // hold > 0: keep request high that many cycles after ready; hold < 0: drop it right after acceptance.
    task automatic do_access(input bit s, input bit w, input logic [1:0] wd, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lat,
                             input bit exp_err, input int hold);
        int lat;
        bit got;
        logic [31:0] e;
        sel = s; addr = a; width = wd; we = w; wdata = d;
        if (s) req3 = 1'b1; else req0 = 1'b1;
        if (!w) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        if (hold < 0) begin req0 = 1'b0; req3 = 1'b0; end
        addr = 32'h3A5; wdata = 32'h5A5A5A5A; we = ~w;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cur_rdy) got = 1'b1;
        end
        check("latency", lat, exp_lat);
        check("err_with_ready", {31'd0, cur_err}, {31'd0, exp_err});
        if (!w) begin
            e = exp_q.pop_front();
            check("read_data", cur_din, e);
            last_rd[s] = e;
        end else begin
            check("data_in_held_on_write", cur_din, last_rd[s]);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("ready_held", {31'd0, cur_rdy}, 32'd1);
        end
        req0 = 1'b0; req3 = 1'b0;
        @(posedge clk);
        #1;
        check("ready_dropped", {31'd0, cur_rdy}, 32'd0);
        check("err_dropped", {31'd0, cur_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1'b1, 2'b10, 32'h010, 32'hDEADBEEF, 32'h0,        5};
        vecs[1]  = '{1'b0, 2'b10, 32'h010, 32'h0,        32'hDEADBEEF, 5};
        vecs[2]  = '{1'b0, 2'b00, 32'h013, 32'h0,        32'h000000DE, 2};
        vecs[3]  = '{1'b0, 2'b01, 32'h012, 32'h0,        32'h0000DEAD, 3};
        vecs[4]  = '{1'b0, 2'b00, 32'h010, 32'h0,        32'h000000EF, 2};
        vecs[5]  = '{1'b1, 2'b10, 32'h040, 32'hCAFEF00D, 32'h0,        5};
        vecs[6]  = '{1'b1, 2'b01, 32'h042, 32'h12347788, 32'h0,        3};
        vecs[7]  = '{1'b1, 2'b00, 32'h041, 32'hABCDEF55, 32'h0,        2};
        vecs[8]  = '{1'b0, 2'b10, 32'h040, 32'h0,        32'h7788550D, 5};
        vecs[9]  = '{1'b0, 2'b11, 32'h040, 32'h0,        32'h7788550D, 5};
        vecs[10] = '{1'b1, 2'b10, 32'h020, 32'h00000000, 32'h0,        5};
        vecs[11] = '{1'b1, 2'b10, 32'h024, 32'h00000000, 32'h0,        5};

        rst0 = 1'b0; rst3 = 1'b0; req0 = 1'b0; req3 = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; width = 2'b00; sel = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready0", {31'd0, rdy0}, 32'd0);
        check("reset_data0", din0, 32'd0);
        check("reset_err0", {31'd0, err0}, 32'd0);
        check("reset_ready3", {31'd0, rdy3}, 32'd0);
        check("reset_data3", din3, 32'd0);
        check("reset_err3", {31'd0, err3}, 32'd0);
        rst0 = 1'b1; rst3 = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++)
            do_access(1'b0, vecs[i].we, vecs[i].wd, vecs[i].a, vecs[i].d, vecs[i].exp, vecs[i].lat, 1'b0, 0);

        // Request held for three cycles after ready.
        do_access(1'b0, 1'b0, 2'b00, 32'h010, 32'h0, 32'h000000EF, 2, 1'b0, 3);
        // Request dropped during ACCESS: write completes, ready pulses once.
        do_access(1'b0, 1'b1, 2'b10, 32'h080, 32'h01020304, 32'h0, 5, 1'b0, -1);
        do_access(1'b0, 1'b0, 2'b10, 32'h080, 32'h0, 32'h01020304, 5, 1'b0, 0);

`ifdef MEM_RESP_ALIGN_CHECK_EN
        do_access(1'b0, 1'b1, 2'b10, 32'h021, 32'hAABBCCDD, 32'h0, 1, 1'b1, 0);
        do_access(1'b0, 1'b0, 2'b10, 32'h020, 32'h0, 32'h00000000, 5, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b10, 32'h024, 32'h0, 32'h00000000, 5, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b01, 32'h011, 32'h0, 32'h00000000, 1, 1'b1, 0);
`else
        do_access(1'b0, 1'b1, 2'b10, 32'h3FF, 32'h11223344, 32'h0, 5, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b00, 32'h3FF, 32'h0, 32'h00000044, 2, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b00, 32'h000, 32'h0, 32'h00000033, 2, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b10, 32'h3FF, 32'h0, 32'h11223344, 5, 1'b0, 0);
        do_access(1'b0, 1'b1, 2'b10, 32'h021, 32'hAABBCCDD, 32'h0, 5, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b10, 32'h020, 32'h0, 32'hBBCCDD00, 5, 1'b0, 0);
        do_access(1'b0, 1'b0, 2'b10, 32'h024, 32'h0, 32'h000000AA, 5, 1'b0, 0);
`endif

        // Three wait states: 16-bit accesses complete 6 cycles after acceptance.
        do_access(1'b1, 1'b1, 2'b01, 32'h010, 32'h0000BEEF, 32'h0, 6, 1'b0, 0);
        do_access(1'b1, 1'b0, 2'b01, 32'h010, 32'h0, 32'h0000BEEF, 6, 1'b0, 0);

        // Reset during ACCESS after one byte has been written.
        sel = 1'b1; addr = 32'h010; width = 2'b10; we = 1'b1; wdata = 32'h11112222;
        req3 = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        @(posedge clk);
        #1;
        rst3 = 1'b1; req3 = 1'b0;
        check("abort_ready", {31'd0, rdy3}, 32'd0);
        check("abort_data", din3, 32'd0);
        check("abort_err", {31'd0, err3}, 32'd0);
        last_rd[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_ready_stays_low", {31'd0, rdy3}, 32'd0);
        do_access(1'b1, 1'b0, 2'b01, 32'h010, 32'h0, 32'h0000BE22, 6, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the mux memory bus. It accepts one request at a time on the request/ready four-phase handshake and services it against an internal byte-wide RAM, one byte per cycle. Accesses are 8, 16 or 32 bits wide and little-endian. It sits below mem_mux and stands in for the backing store in simulation and FPGA builds.

Parameters:
- M_WIDTH, 32: address and data bus width.
- AW, 10: RAM holds 2**AW bytes; byte address = mem_addr[AW-1:0].
- WAIT_STATES, 0: extra idle cycles inserted after the last byte, before ready.
- MEM_ACC_8, 2'b00: width code for 1 byte.
- MEM_ACC_16, 2'b01: width code for 2 bytes.
- MEM_ACC_32, 2'b10: width code for 4 bytes; 2'b11 is also treated as 4 bytes.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low (0 = reset).
- mem_request  input  1  access request from the mux.
- mem_addr  input  M_WIDTH  byte address.
- mem_data_width  input  2  access width code.
- mem_we_out  input  1  1 = write, 0 = read.
- mem_data_out  input  M_WIDTH  write data; low bytes used.
- mem_ready  output  1  access complete.
- mem_data_in  output  M_WIDTH  read data, zero-extended.
- mem_err  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset (rst=0 at a clock edge): state=IDLE; mem_ready=0, mem_data_in=0, mem_err=0, byte counter=0, wait counter=0. RAM contents are not cleared. Reset mid-access aborts the access immediately. Bytes already written stay written.
- States: IDLE, ACCESS, WAIT, DONE.
- IDLE, mem_request=1 sampled: accept the request.
  - Latch addr, width, we and data. Input changes after acceptance are ignored.
  - Set N = 1, 2 or 4 bytes; byte counter k=0; go to ACCESS.
- ACCESS: one byte per cycle at address (A+k) mod 2**AW.
  - Write: RAM[(A+k)] <= data[8k+:8].
  - Read: shadow register byte k <= RAM[(A+k)]; upper unused bytes are 0.
  - After byte N-1: go to WAIT if WAIT_STATES>0, else DONE.
- WAIT: count WAIT_STATES cycles, then go to DONE.
- DONE: mem_ready=1.
  - For reads, mem_data_in is loaded from the shadow register on DONE entry.
  - Stay in DONE while mem_request=1.
  - When mem_request=0 is sampled, go to IDLE; mem_ready drops the next cycle.
- Latency: ready first high N+WAIT_STATES+1 cycles after the acceptance edge. Example: 32-bit access, WAIT_STATES=0 → ready high in cycle 5.
- mem_data_in changes only on read completion. It holds its value across writes and idle periods.
- mem_request dropped before ready: the access still completes in full. DONE then lasts exactly one cycle (1-cycle ready pulse), then IDLE.
- Back-to-back: a request that is still high in IDLE after DONE is a new access. The earliest new acceptance is 1 cycle after ready drops.
- Address wrap: a multi-byte access at 2**AW-1 continues at byte 0.
- mem_err=0 and all accesses proceed bytewise unless the feature below is enabled.

Optional Feature:
Macro: MEM_RESP_ALIGN_CHECK_EN.
- Defined: an access is misaligned when it is 16-bit with A[0]=1, or 32-bit with A[1:0]!=0.
  - A misaligned access skips ACCESS and WAIT and goes straight to DONE.
  - No RAM write occurs; a read loads mem_data_in=0.
  - mem_err=1 together with mem_ready; both clear together.
- Undefined: no check is made, misaligned accesses are performed bytewise with wrap, and mem_err is tied to 0.

Test Plan:
- Write then read, 32-bit, WAIT_STATES=0: write 0xDEADBEEF at 0x10, then read 0x10 → mem_data_in=0xDEADBEEF; ready rises in cycle 5 after acceptance; byte 0x10 = 0xEF.
- 8-bit read of 0x13 after the first test → mem_data_in=0x000000DE. A 16-bit read of 0x12 → 0x0000DEAD.
- Wrap-around, AW=10: 32-bit write 0x11223344 at 0x3FF → byte 0x3FF=0x44, byte 0x000=0x33; a 32-bit read at 0x3FF returns 0x11223344.
- Handshake: hold mem_request high for 3 cycles after ready → ready stays high for those cycles and drops 1 cycle after request falls. Dropping request during ACCESS → write still completes and ready pulses for exactly 1 cycle.
- WAIT_STATES=3: 16-bit read → ready rises 6 cycles after acceptance. Asserting rst=0 while in ACCESS → next cycle IDLE with all outputs 0.
- With MEM_RESP_ALIGN_CHECK_EN: 32-bit write at 0x21 → mem_ready and mem_err rise in cycle 1 and the RAM is unchanged. Without the macro, the same access writes bytes 0x21–0x24 and mem_err=0.
